// File: rtl/riscv_pkg.sv
// Shared register-file types and the write-port arbitration helper.
// Sized for the architectural 32-entry file; the helper works on padded port vectors.
package riscv_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;

  localparam int MAX_WR_PORTS = 4;
  localparam int MAX_ADDR_W   = 16;

  // Highest-index enabled port whose address matches target, or -1 when none does.
  function automatic int wr_winner(
    input logic [MAX_WR_PORTS-1:0]            en,
    input logic [MAX_WR_PORTS*MAX_ADDR_W-1:0] addr,
    input logic [MAX_ADDR_W-1:0]              target
  );
    int win;
    win = -1;
    for (int unsigned p = 0; p < MAX_WR_PORTS; p++) begin
      if (en[p] && (addr[p*MAX_ADDR_W +: MAX_ADDR_W] == target)) win = int'(p);
    end
    return win;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector: set at issue, cleared at writeback, set wins over clear.
module reg_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REGS-1:0] set_i,
  input  logic [NUM_REGS-1:0] clr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d    = (busy_q & ~clr_i) | set_i;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with x0 hardwired to zero, optional write bypass,
// optional registered read and a busy scoreboard for operand-ready stalls.
module register_file_mp
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter int NUM_RD_PORTS = 4,
  parameter int NUM_WR_PORTS = 2,
  parameter int READ_LATENCY = 0,
  parameter int BYPASS_EN    = 1,
  parameter int INIT_INDEX   = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD_PORTS-1:0]          rd_busy_o,
  input  logic [NUM_WR_PORTS-1:0]          wr_en_i,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_WR_PORTS-1:0]          rsv_en_i,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] rsv_addr_i,
  output logic                             wr_conflict_o
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] idx_t;
  localparam idx_t ZERO_IDX = idx_t'(REG_ZERO);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];
  word_t rd_comb [NUM_RD_PORTS];
  word_t rd_post [NUM_RD_PORTS];
  word_t rd_q    [NUM_RD_PORTS];

  logic [MAX_WR_PORTS-1:0]            wr_act;
  logic [MAX_WR_PORTS*MAX_ADDR_W-1:0] wr_addr_ext;
  logic [NUM_REGS-1:0]                set_vec, clr_vec, busy;
  logic                               conflict_d, conflict_q;
  idx_t                               ra;
  int                                 win;

  // Write decode: x0 writes/reserves are dropped before they reach merge, conflict or scoreboard.
  always_comb begin
    wr_act      = '0;
    wr_addr_ext = '0;
    set_vec     = '0;
    clr_vec     = '0;
    conflict_d  = 1'b0;
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      wr_act[p] = wr_en_i[p] && (wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_IDX);
      wr_addr_ext[p*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
      if (wr_act[p]) clr_vec[wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      if (rsv_en_i[p] && (rsv_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_IDX))
        set_vec[rsv_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
    end
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR_PORTS; q++) begin
        if (wr_act[p] && wr_act[q] &&
            (wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_i[q*ADDR_WIDTH +: ADDR_WIDTH]))
          conflict_d = 1'b1;
      end
    end
  end

  // Ascending port order makes the highest enabled port the last, winning assignment.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_act[p]) regs_d[wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ra        = '0;
    win       = -1;
    rd_busy_o = '0;
    for (int unsigned r = 0; r < NUM_RD_PORTS; r++) begin
      ra  = rd_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
      win = wr_winner(wr_act, wr_addr_ext, MAX_ADDR_W'(ra));
      rd_comb[r] = regs_q[ra];
      if ((BYPASS_EN != 0) && (win >= 0)) rd_comb[r] = wr_data_i[win*DATA_WIDTH +: DATA_WIDTH];
      if (ra == ZERO_IDX) rd_comb[r] = '0;
      rd_post[r] = (ra == ZERO_IDX) ? '0 : ((BYPASS_EN != 0) ? regs_d[ra] : regs_q[ra]);
      rd_busy_o[r] = busy[ra] && !((BYPASS_EN != 0) && clr_vec[ra] && !set_vec[ra]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (INIT_INDEX != 0) ? DATA_WIDTH'(i) : '0;
      for (int unsigned r = 0; r < NUM_RD_PORTS; r++) rd_q[r] <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rd_q       <= rd_post;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned r = 0; r < NUM_RD_PORTS; r++)
      rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = (READ_LATENCY != 0) ? rd_q[r] : rd_comb[r];
  end

  assign wr_conflict_o = conflict_q;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .set_i  (set_vec),
    .clr_i  (clr_vec),
    .busy_o (busy)
  );

endmodule
